// File: rtl/kgp_isa_pkg.sv
// KGPminiRISC ISA encodings shared by the decoder, ALU and branch unit.
package kgp_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_COMPI = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b000100;
  localparam logic [5:0] OP_BREG  = 6'b000101;
  localparam logic [5:0] OP_BLBL  = 6'b000110;

  localparam logic [4:0] FN_FIRST = 5'b00001;
  localparam logic [4:0] FN_SHLL  = 5'b00101;
  localparam logic [4:0] FN_SHRL  = 5'b00110;
  localparam logic [4:0] FN_SHRA  = 5'b01001;
  localparam logic [4:0] FN_LAST  = 5'b01011;

  // Branch sub-ops: BREG uses br/bltz/bz/bnz, BLBL uses b/bl/bcy/bncy
  localparam logic [4:0] FN_BR0 = 5'b00000;
  localparam logic [4:0] FN_BR1 = 5'b00001;
  localparam logic [4:0] FN_BR2 = 5'b00010;
  localparam logic [4:0] FN_BR3 = 5'b00011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_COMP = 5'b00010;
  localparam logic [4:0] ALU_PASS = 5'b01100;

  localparam logic [1:0] RD_RS  = 2'b00;
  localparam logic [1:0] RD_RT  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic [1:0] regDst;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic [1:0] memToReg;
    logic       ALUsrc;
    logic [4:0] ALUop;
    logic       ALUsel;
    logic       branch;
    logic       jumpAddr;
    logic       lblSel;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode/func to control-bundle decode; unlisted encodings yield NOP.
module control_decode
  import kgp_isa_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [4:0] i_func,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_RTYPE: begin
        if (i_func >= FN_FIRST && i_func <= FN_LAST) begin
          o_ctrl.regWrite = 1'b1;
          o_ctrl.regDst   = RD_RS;
          o_ctrl.memToReg = WB_ALU;
          o_ctrl.ALUop    = i_func;
          o_ctrl.ALUsel   = (i_func == FN_SHLL) || (i_func == FN_SHRL) || (i_func == FN_SHRA);
        end
      end
      OP_ADDI, OP_COMPI: begin
        o_ctrl.regWrite = 1'b1;
        o_ctrl.regDst   = RD_RS;
        o_ctrl.ALUsrc   = 1'b1;
        o_ctrl.ALUop    = (i_opcode == OP_ADDI) ? ALU_ADD : ALU_COMP;
      end
      OP_LW: begin
        o_ctrl.regWrite = 1'b1;
        o_ctrl.regDst   = RD_RT;
        o_ctrl.memRead  = 1'b1;
        o_ctrl.memToReg = WB_MEM;
        o_ctrl.ALUsrc   = 1'b1;
        o_ctrl.ALUop    = ALU_ADD;
      end
      OP_SW: begin
        o_ctrl.memWrite = 1'b1;
        o_ctrl.ALUsrc   = 1'b1;
        o_ctrl.ALUop    = ALU_ADD;
      end
      OP_BREG: begin
        if (i_func == FN_BR0 || i_func == FN_BR1 || i_func == FN_BR2 || i_func == FN_BR3) begin
          o_ctrl.branch   = 1'b1;
          o_ctrl.ALUop    = ALU_PASS;
          o_ctrl.jumpAddr = (i_func == FN_BR0);
        end
      end
      OP_BLBL: begin
        if (i_func == FN_BR0 || i_func == FN_BR1 || i_func == FN_BR2 || i_func == FN_BR3) begin
          o_ctrl.branch   = 1'b1;
          o_ctrl.lblSel   = 1'b1;
          o_ctrl.ALUop    = ALU_NONE;
          o_ctrl.jumpAddr = (i_func == FN_BR0) || (i_func == FN_BR1);
          // bl links: r31 <- PC+4
          if (i_func == FN_BR1) begin
            o_ctrl.regWrite = 1'b1;
            o_ctrl.regDst   = RD_R31;
            o_ctrl.memToReg = WB_PC4;
          end
        end
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// KGPminiRISC main decoder: combinational decode followed by one register stage.
module control_unit
  import kgp_isa_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [4:0] func,
  output logic [1:0] regDst,
  output logic       regWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic [1:0] memToReg,
  output logic       ALUsrc,
  output logic [4:0] ALUop,
  output logic       ALUsel,
  output logic       branch,
  output logic       jumpAddr,
  output logic       lblSel
);

  ctrl_t w_ctrl;
  ctrl_t r_ctrl;

  control_decode u_decode (
    .i_opcode (opcode),
    .i_func   (func),
    .o_ctrl   (w_ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) r_ctrl <= '0;
    else     r_ctrl <= w_ctrl;
  end

  assign regDst   = r_ctrl.regDst;
  assign regWrite = r_ctrl.regWrite;
  assign memRead  = r_ctrl.memRead;
  assign memWrite = r_ctrl.memWrite;
  assign memToReg = r_ctrl.memToReg;
  assign ALUsrc   = r_ctrl.ALUsrc;
  assign ALUop    = r_ctrl.ALUop;
  assign ALUsel   = r_ctrl.ALUsel;
  assign branch   = r_ctrl.branch;
  assign jumpAddr = r_ctrl.jumpAddr;
  assign lblSel   = r_ctrl.lblSel;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes hand-computed controls, monitor compares a cycle later.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [4:0] func = '0;
  logic [1:0] regDst, memToReg;
  logic       regWrite, memRead, memWrite, ALUsrc, ALUsel, branch, jumpAddr, lblSel;
  logic [4:0] ALUop;

  control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .regDst(regDst), .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
    .memToReg(memToReg), .ALUsrc(ALUsrc), .ALUop(ALUop), .ALUsel(ALUsel),
    .branch(branch), .jumpAddr(jumpAddr), .lblSel(lblSel)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [16:0] exp;
  } sb_t;

  sb_t sb[$];
  int  errors = 0;
  int  checks = 0;
  bit  done   = 1'b0;

  function automatic logic [16:0] cv(logic [1:0] rd, logic rw, logic mr, logic mw,
                                     logic [1:0] m2r, logic as, logic [4:0] aop,
                                     logic asel, logic br, logic ja, logic lbl);
    return {rd, rw, mr, mw, m2r, as, aop, asel, br, ja, lbl};
  endfunction

  task automatic issue(input string nm, input logic r, input logic [5:0] op,
                       input logic [4:0] fn, input logic [16:0] exp);
    sb_t it;
    @(negedge clk);
    rst = r; opcode = op; func = fn;
    it.name = nm; it.exp = exp;
    sb.push_back(it);
  endtask

  // Monitor: every loaded edge produces one output vector to check
  initial begin
    sb_t it;
    logic [16:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        it  = sb.pop_front();
        act = {regDst, regWrite, memRead, memWrite, memToReg, ALUsrc, ALUop,
               ALUsel, branch, jumpAddr, lblSel};
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: done=%0d expected 1", done);
    $fatal(1, "timeout");
  end

  initial begin
    issue("reset",      1'b1, 6'b000001, 5'b00000, '0);
    issue("addi",       1'b0, 6'b000001, 5'b10101, cv(2'b00,1,0,0,2'b00,1,5'b00001,0,0,0,0));
    issue("nop_r0",     1'b0, 6'b000000, 5'b00000, '0);
    issue("nop_op7",    1'b0, 6'b000111, 5'b10101, '0);
    issue("r_add",      1'b0, 6'b000000, 5'b00001, cv(2'b00,1,0,0,2'b00,0,5'b00001,0,0,0,0));
    issue("r_shll",     1'b0, 6'b000000, 5'b00101, cv(2'b00,1,0,0,2'b00,0,5'b00101,1,0,0,0));
    issue("r_shrl",     1'b0, 6'b000000, 5'b00110, cv(2'b00,1,0,0,2'b00,0,5'b00110,1,0,0,0));
    issue("r_shllv",    1'b0, 6'b000000, 5'b00111, cv(2'b00,1,0,0,2'b00,0,5'b00111,0,0,0,0));
    issue("r_shra",     1'b0, 6'b000000, 5'b01001, cv(2'b00,1,0,0,2'b00,0,5'b01001,1,0,0,0));
    issue("r_diff",     1'b0, 6'b000000, 5'b01011, cv(2'b00,1,0,0,2'b00,0,5'b01011,0,0,0,0));
    issue("r_fn12",     1'b0, 6'b000000, 5'b01100, '0);
    issue("r_fn31",     1'b0, 6'b000000, 5'b11111, '0);
    issue("compi",      1'b0, 6'b000010, 5'b11111, cv(2'b00,1,0,0,2'b00,1,5'b00010,0,0,0,0));
    issue("lw",         1'b0, 6'b000011, 5'b00000, cv(2'b01,1,1,0,2'b01,1,5'b00001,0,0,0,0));
    issue("sw",         1'b0, 6'b000100, 5'b00000, cv(2'b00,0,0,1,2'b00,1,5'b00001,0,0,0,0));
    issue("br",         1'b0, 6'b000101, 5'b00000, cv(2'b00,0,0,0,2'b00,0,5'b01100,0,1,1,0));
    issue("bltz",       1'b0, 6'b000101, 5'b00001, cv(2'b00,0,0,0,2'b00,0,5'b01100,0,1,0,0));
    issue("bz",         1'b0, 6'b000101, 5'b00010, cv(2'b00,0,0,0,2'b00,0,5'b01100,0,1,0,0));
    issue("bnz",        1'b0, 6'b000101, 5'b00011, cv(2'b00,0,0,0,2'b00,0,5'b01100,0,1,0,0));
    issue("breg_bad",   1'b0, 6'b000101, 5'b00100, '0);
    issue("b",          1'b0, 6'b000110, 5'b00000, cv(2'b00,0,0,0,2'b00,0,5'b00000,0,1,1,1));
    issue("bl",         1'b0, 6'b000110, 5'b00001, cv(2'b10,1,0,0,2'b10,0,5'b00000,0,1,1,1));
    issue("bcy",        1'b0, 6'b000110, 5'b00010, cv(2'b00,0,0,0,2'b00,0,5'b00000,0,1,0,1));
    issue("bncy",       1'b0, 6'b000110, 5'b00011, cv(2'b00,0,0,0,2'b00,0,5'b00000,0,1,0,1));
    issue("blbl_bad",   1'b0, 6'b000110, 5'b00101, '0);
    issue("op63",       1'b0, 6'b111111, 5'b00001, '0);
    issue("lw_pre_rst", 1'b0, 6'b000011, 5'b00000, cv(2'b01,1,1,0,2'b01,1,5'b00001,0,0,0,0));
    issue("mid_rst",    1'b1, 6'b000100, 5'b00000, '0);
    issue("post_rst",   1'b0, 6'b000100, 5'b00000, cv(2'b00,0,0,1,2'b00,1,5'b00001,0,0,0,0));
    issue("bl_again",   1'b0, 6'b000110, 5'b00001, cv(2'b10,1,0,0,2'b10,0,5'b00000,0,1,1,1));
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Main decoder of the KGPminiRISC single-issue datapath. It takes the instruction's 6-bit opcode and 5-bit function field and produces every datapath control strobe:
- register-file destination and write enable;
- data-memory read and write;
- writeback source;
- ALU operand source and operation;
- branch and jump steering.

Outputs are registered, so they appear one clock cycle after the opcode and function field are presented.

## Interface
- Parameters: none.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset; clears every output register.
- opcode  in  6  instruction class (instr[31:26]).
- func  in  5  function/sub-op field (instr[4:0]).
- regDst  out  2  destination register select: 00 = rs field, 01 = rt field, 10 = r31 (link).
- regWrite  out  1  register-file write enable.
- memRead  out  1  data-memory read enable.
- memWrite  out  1  data-memory write enable.
- memToReg  out  2  writeback source: 00 = ALU result, 01 = memory data, 10 = PC+4.
- ALUsrc  out  1  ALU B operand: 0 = rt register, 1 = sign-extended immediate.
- ALUop  out  5  ALU operation code.
- ALUsel  out  1  shift amount source: 1 = shamt field, 0 = register or immediate path.
- branch  out  1  the instruction is a branch or jump.
- jumpAddr  out  1  unconditional transfer (b, bl, br).
- lblSel  out  1  target source: 1 = PC-relative label, 0 = register rs.

## Operation
- ALUop codes:
  - 00001 add, 00010 comp (2's complement), 00011 and, 00100 xor.
  - 00101 shll, 00110 shrl, 00111 shllv, 01000 shrlv, 01001 shra, 01010 shrav.
  - 01011 diff, 01100 pass-A (flag generation), 00000 none.
- Default for any unlisted case: all outputs 0 (NOP).
- opcode 000000, R-type ALU, rs ← rs op rt:
  - Valid func 00001–01011: regWrite=1, regDst=00, memToReg=00, ALUsrc=0, ALUop=func.
  - ALUsel=1 only for constant shifts (func 00101, 00110, 01001).
  - Any other func (including 00000) decodes as NOP.
- opcode 000001, addi: regWrite=1, regDst=00, ALUsrc=1, ALUop=00001. func ignored.
- opcode 000010, compi: as addi but ALUop=00010.
- opcode 000011, lw, rt ← mem[rs+imm]: regWrite=1, regDst=01, memRead=1, memToReg=01, ALUsrc=1, ALUop=00001.
- opcode 000100, sw: memWrite=1, ALUsrc=1, ALUop=00001, regWrite=0.
- opcode 000101, register/condition branches, branch=1, lblSel=0, ALUop=01100:
  - func 00000 br: jumpAddr=1.
  - func 00001 bltz, 00010 bz, 00011 bnz: jumpAddr=0.
  - Other func: NOP.
- opcode 000110, label branches, branch=1, lblSel=1, ALUop=00000:
  - func 00000 b: jumpAddr=1.
  - func 00001 bl: jumpAddr=1, regWrite=1, regDst=10, memToReg=10.
  - func 00010 bcy, 00011 bncy: jumpAddr=0.
  - Other func: NOP.
- opcode 000111 and all opcodes ≥ 000111: NOP.
- memRead and memWrite are never both 1. regWrite=0 whenever memWrite=1.

## Timing
- Decode is combinational; every output is a flop loaded at the rising edge of clk.
- Latency is exactly 1 cycle from opcode/func to outputs. No handshake; a new decode is accepted every cycle.
- rst=1 at an edge forces all outputs to 0, regardless of inputs.
- Reset asserted mid-stream discards the pending decode. Outputs track inputs again on the first edge after rst deasserts.
- X or unknown encodings must not propagate: unlisted opcode/func values decode to NOP.

## Structure
- Shared package `kgp_isa_pkg` holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_COMPI, OP_LW, OP_SW, OP_BREG, OP_BLBL);
  - func constants;
  - ALUop constants;
  - regDst and memToReg encodings.
- ALU and branch unit also import `kgp_isa_pkg`.
- One natural sub-module, `control_decode`: purely combinational opcode/func → control bundle.
- The top level adds the output register stage and reset.

## Test plan
- Reset: rst=1 with opcode 000001 → after the edge all outputs 0. Deassert rst → next edge shows the addi controls.
- NOP: opcode 000000, func 00000 → all outputs 0. Opcode 000111, any func → all outputs 0.
- R-type:
  - func 00001 → regWrite=1, regDst=00, ALUsrc=0, ALUop=00001, ALUsel=0.
  - func 00101 → ALUop=00101, ALUsel=1.
  - func 11111 → NOP.
- Immediates and memory:
  - 000001 → regWrite=1, ALUsrc=1, ALUop=00001.
  - 000010 → ALUop=00010.
  - 000011 → regDst=01, memRead=1, memToReg=01.
  - 000100 → memWrite=1, regWrite=0.
- Branches:
  - 000101/00000 → branch=1, jumpAddr=1, lblSel=0.
  - 000101/00010 → branch=1, jumpAddr=0, ALUop=01100.
  - 000110/00001 → branch=1, jumpAddr=1, lblSel=1, regWrite=1, regDst=10, memToReg=10.
- Latency: toggle opcode every cycle → each output vector matches the decode of the previous cycle's inputs.
